// File: rtl/oam_dma.sv
// oam_dma: NES sprite DMA engine and shared bus mux.
// A CPU write to DMA_REG copies 256 bytes from CPU page {XX,00..FF} into the
// PPU OAM data port, stalling the CPU for the whole copy.
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_DATA = 16'h2004,
  parameter int          BYTES    = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  input  logic        cpu_rd,
  input  logic [7:0]  mem_in,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_out,
  output logic        bus_we,
  output logic        bus_rd,
  output logic        lock_cpu,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  localparam logic [8:0] LAST_IDX = 9'(BYTES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_phase;
  logic [7:0]  r_page;
  logic [8:0]  r_idx;
  logic        w_trigger;
  logic        w_lastByte;

  // A trigger is only accepted while idle; writes during a copy are ignored.
  assign w_trigger  = (r_state == IDLE) && cpu_we && (cpu_address == DMA_REG);
  assign w_lastByte = (r_idx == LAST_IDX);
  assign busy       = lock_cpu;

  // Free-running get/put parity toggle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Source page latch and byte index; index advances once per OAM write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_page <= 8'h00;
      r_idx  <= 9'd0;
    end else if (w_trigger) begin
      r_page <= cpu_out;
      r_idx  <= 9'd0;
    end else if (r_state == WRITE) begin
      r_idx <= r_idx + 9'd1;
    end
  end

  // Next-state logic and bus mux: CPU passes through when idle, DMA owns the bus otherwise.
  always_comb begin
    w_next      = r_state;
    bus_address = cpu_address;
    bus_out     = cpu_out;
    bus_we      = cpu_we;
    bus_rd      = cpu_rd;
    lock_cpu    = 1'b0;

    if (r_state != IDLE) begin
      lock_cpu    = 1'b1;
      bus_address = {r_page, r_idx[7:0]};
      bus_out     = 8'h00;
      bus_we      = 1'b0;
      bus_rd      = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_next = HALT;
        end
      end
      HALT: begin
        w_next = r_phase ? ALIGN : READ;
      end
      ALIGN: begin
        w_next = READ;
      end
      READ: begin
        bus_rd = 1'b1;
        w_next = WRITE;
      end
      WRITE: begin
        bus_address = OAM_DATA;
        bus_out     = mem_in;
        bus_we      = 1'b1;
        w_next      = w_lastByte ? IDLE : READ;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine for the NES core. It sits between the CPU bus (nes) and the PPU register port.
- A CPU write to $4014 starts a copy of 256 bytes from CPU page XX00–XXFF into PPU $2004 (OAM data).
- While the copy runs, the CPU is stalled and the block owns the shared bus.
- It also provides the bus mux, so the ppu and the memory see a single address/data/we/rd set.

Parameters:
- DMA_REG, 16'h4014, CPU address that triggers DMA.
- OAM_DATA, 16'h2004, destination register address.
- BYTES, 256, bytes per transfer (9-bit counter).

Ports:
- clock  in  1  system clock (CPU/PPU domain).
- reset  in  1  asynchronous, active-high reset.
- cpu_address  in  16  CPU address.
- cpu_out  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_rd  in  1  CPU read strobe.
- mem_in  in  8  bus read data; valid one clock after the address is presented.
- bus_address  out  16  muxed bus address.
- bus_out  out  8  muxed write data.
- bus_we  out  1  muxed write strobe.
- bus_rd  out  1  muxed read strobe.
- lock_cpu  out  1  stalls the CPU; it holds all state while this is high.
- busy  out  1  transfer in progress (same as lock_cpu, kept for status/debug).

Behaviour:
- Reset (async, immediate):
  - state=IDLE, page=0, idx=0, phase=0.
  - lock_cpu=0, busy=0.
  - The bus mux passes CPU signals straight through.
- phase:
  - Free-running toggle every clock, starting at 0 after reset.
  - Models the CPU get/put cycle parity.
- Bus mux:
  - When lock_cpu=0, bus_* = cpu_* combinationally.
  - When lock_cpu=1, bus_* come from the DMA. cpu_we and cpu_rd are ignored.
- Trigger: in IDLE, on posedge with cpu_we=1 and cpu_address==DMA_REG:
  - page<=cpu_out, idx<=0, state<=HALT.
  - The trigger write itself also passes to the bus unchanged.
- States:
  - IDLE: lock_cpu=0.
  - HALT: one cycle, lock_cpu=1, no bus activity (bus_we=0, bus_rd=0). Next state is ALIGN if phase==1 in HALT, else READ.
  - ALIGN: one dummy cycle, no bus activity, then READ.
  - READ: bus_address={page,idx[7:0]}, bus_rd=1, bus_we=0. Next state is WRITE.
  - WRITE:
    - bus_address=OAM_DATA, bus_out=mem_in (combinational pass of the data read in the previous cycle), bus_we=1, bus_rd=0.
    - idx<=idx+1.
    - If idx==BYTES-1, go to IDLE; else go to READ.
- Latency:
  - lock_cpu rises in the cycle after the trigger edge.
  - It falls in the cycle after the last WRITE.
  - Total locked cycles: 513 (even alignment) or 514 (odd alignment).
- Address arithmetic:
  - idx is 9 bits; only idx[7:0] goes on the address.
  - The source never crosses the page: page FF reads FF00–FFFF, with no wrap into page 00.
- Boundary conditions:
  - A write to DMA_REG while busy cannot happen, because the CPU is locked. If cpu_we is nevertheless asserted, it is ignored and does not retrigger.
  - A CPU read of DMA_REG does nothing.
  - A write to DMA_REG in the same cycle the transfer finishes (the last WRITE) is ignored. A trigger is only accepted in IDLE.
  - Reset mid-transfer: lock_cpu drops to 0 asynchronously and state returns to IDLE. The OAM contents already written stay as they are.
- bus_out when no DMA write occurs:
  - In HALT, ALIGN and READ it is 8'h00.
  - In IDLE it is cpu_out.

Test Plan:
- Basic copy:
  - Stimulus: preload memory 0x0200+i = i^8'h5A, then CPU writes 8'h02 to 4014 with phase=0 at HALT.
  - Required: lock_cpu high for exactly 513 cycles; 256 writes to 2004 with data 5A,5B,58,… in order; bus_rd addresses 0200..02FF ascending.
- Odd alignment: same trigger delayed one clock so that phase=1 in HALT → one ALIGN cycle; lock_cpu high for 514 cycles; data sequence unchanged.
- Passthrough: with no DMA, CPU write 8'h33 to 0x0010 and a read of 0x0011 → bus_* equal cpu_* in the same cycle; lock_cpu=0 throughout.
- Page FF: trigger with 8'hFF → last read address FFFF, no access to 0000; 256th write to 2004 carries memory[FFFF].
- Reset mid-transfer: assert reset after 100 writes → lock_cpu=0 and busy=0 immediately, with no further writes to 2004. A fresh trigger after release restarts from idx=0 (first read at {page,8'h00}).
- Spurious trigger: force cpu_we=1 with address 4014 during busy → no restart and idx continues; a CPU read of 4014 in IDLE → no transfer.
